imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Upstream feeder for the single-cycle core's instruction memory.
- Holds the core in reset and receives a byte stream from the host link (valid/ready). The stream carries a 32-bit word count followed by that many little-endian instruction words.
- Writes each assembled word into instruction memory at consecutive word addresses, then releases the core's reset.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity DEPTH = 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid & in_ready at a rising edge.
- im_we  output  1  one-cycle instruction-memory write strobe.
- im_addr  output  ADDR_WIDTH  word index to write; byte address = im_addr<<2.
- im_wdata  output  32  instruction word to write.
- cpu_rst  output  1  reset to core (programCounter, etc.); high while loading.
- load_done  output  1  sticky; load completed successfully.
- load_err  output  1  sticky; declared length exceeds DEPTH.
- word_count  output  ADDR_WIDTH+1  words written so far.

Behaviour:
- All outputs are registered.
- Reset values (async, immediate on rst high):
  - in_ready=0, im_we=0, im_addr=0, im_wdata=0.
  - cpu_rst=1, load_done=0, load_err=0, word_count=0.
  - State=S_LEN, byte_idx=0.
- States:
  - S_LEN: collects 4 length bytes, little-endian; the first byte goes to bits[7:0].
  - S_DATA: collects instruction bytes.
  - S_DONE: load complete.
  - S_ERR: length error.
- in_ready: 1 in S_LEN, S_DATA and S_ERR; 0 in S_DONE. It rises on the first clk edge after rst deasserts.
- S_LEN exit, on acceptance of the 4th length byte (full 32-bit compare):
  - len==0 -> S_DONE.
  - len>DEPTH -> S_ERR.
  - Otherwise -> S_DATA with remaining=len.
- S_DATA: bytes are packed little-endian into a 32-bit shift/assembly register. On the edge accepting the 4th byte of a word:
  - im_we=1 for exactly the following cycle, with im_addr=current word index and im_wdata=assembled word.
  - Word index and word_count increment on the same edge that drops im_we.
- Last word: after the edge that ends the final im_we cycle, state=S_DONE. cpu_rst=0 and load_done=1 take effect on that same edge, i.e. one cycle after the last write strobe.
- len==0: cpu_rst=0 and load_done=1 in the cycle after the 4th length byte's edge. No im_we is ever issued.
- S_ERR:
  - load_err=1.
  - cpu_rst stays 1.
  - Bytes are accepted and discarded (drain).
  - No im_we.
  - Exit only via rst.
- S_DONE: stream ignored (in_ready=0), no further writes, cpu_rst stays 0 until rst.
- in_valid gaps: allowed anywhere. Partial words and length bytes are held indefinitely; there is no timeout.
- Back-to-back bytes at one per cycle are sustained. The im_we cycle does not stall the stream; the next word's first byte may be accepted in the strobe cycle.
- len==DEPTH is legal: the final write goes to im_addr=DEPTH-1 and word_count reaches DEPTH (hence the ADDR_WIDTH+1 width).
- rst mid-operation: everything returns to reset values. Partially assembled data is discarded and the next load restarts at word 0.

Test Plan:
- Nominal: bytes 02 00 00 00 | 13 05 10 00 | 93 05 20 00 at one per cycle.
  - im_we at addr 0 data 0x00100513, then at addr 1 data 0x00200593.
  - cpu_rst falls one cycle after the second strobe; load_done=1; word_count=2.
- Zero length: 00 00 00 00.
  - No im_we; cpu_rst=0 and load_done=1 the cycle after the 4th byte; in_ready=0 afterwards.
- Overflow (ADDR_WIDTH=8): length 01 01 00 00 (257).
  - load_err=1, cpu_rst stays 1, subsequent bytes accepted with no im_we.
  - Length 00 01 00 00 (256) instead loads fully, with the last write at addr 0xFF and word_count=256.
- Throttled stream: the nominal sequence with in_valid high every third cycle.
  - Identical addr/data writes and final state; no lost or duplicated bytes.
- Reset mid-load: assert rst after 6 bytes of the nominal stream, then replay the full stream.
  - Outputs return to reset values immediately; the replay writes 0x00100513 at addr 0 (not addr 1).
- Post-done: after a nominal load, drive 8 more bytes with in_valid=1.
  - in_ready=0, no im_we, cpu_rst stays 0, word_count unchanged.

Source files
------------

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//
// Feeds the instruction memory of the single-cycle core from a host byte
// stream. The core is held in reset while loading. The stream is a 32-bit
// little-endian word count followed by that many little-endian instruction
// words. Each word is written to consecutive word addresses starting at 0.
// After the last word the core is released from reset.
//
// Ports
//   clk, rst    : system clock (rising edge), async active-high reset
//   in_valid    : in_data carries a valid stream byte
//   in_data     : stream byte
//   in_ready    : loader accepts a byte; transfer = in_valid & in_ready @ edge
//   im_we       : one-cycle instruction-memory write strobe
//   im_addr     : word index being written (byte address = im_addr << 2)
//   im_wdata    : instruction word being written
//   cpu_rst     : reset to the core, high until a successful load
//   load_done   : sticky, load completed
//   load_err    : sticky, declared length exceeds DEPTH
//   word_count  : words written so far (0..DEPTH)
// ---------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_rst,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // Capacity in words, widened so the full 32-bit length compare cannot wrap.
  localparam logic [32:0] DEPTH = 33'(1) << ADDR_WIDTH;

  state_t                state_q,       state_d;
  logic [1:0]            byte_idx_q,    byte_idx_d;
  logic [31:0]           asm_q,         asm_d;
  logic [ADDR_WIDTH:0]   remaining_q,   remaining_d;
  logic                  in_ready_q,    in_ready_d;
  logic                  im_we_q,       im_we_d;
  logic [ADDR_WIDTH-1:0] im_addr_q,     im_addr_d;
  logic [31:0]           im_wdata_q,    im_wdata_d;
  logic                  cpu_rst_q,     cpu_rst_d;
  logic                  load_done_q,   load_done_d;
  logic                  load_err_q,    load_err_d;
  logic [ADDR_WIDTH:0]   word_count_q,  word_count_d;

  logic                  xfer;
  logic [31:0]           asm_next;
  logic [ADDR_WIDTH:0]   word_count_inc;

  assign xfer           = in_valid & in_ready_q;
  assign word_count_inc = word_count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};

  // The incoming byte lands in its little-endian lane; after the 4th byte of a
  // group every lane has been overwritten, so stale bytes never leak through.
  always_comb begin
    asm_next = asm_q;
    asm_next[{byte_idx_q, 3'b000} +: 8] = in_data;
  end

  // NOTE: every signal written here gets a default first (hold value or 0);
  // a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    remaining_d  = remaining_q;
    im_we_d      = 1'b0;
    im_addr_d    = im_addr_q;
    im_wdata_d   = im_wdata_q;
    cpu_rst_d    = cpu_rst_q;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
    word_count_d = word_count_q;

    unique case (state_q)
      S_LEN: begin
        if (xfer) begin
          asm_d      = asm_next;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            if (asm_next == 32'd0) begin
              state_d     = S_DONE;
              cpu_rst_d   = 1'b0;
              load_done_d = 1'b1;
            end else if ({1'b0, asm_next} > DEPTH) begin
              state_d    = S_ERR;
              load_err_d = 1'b1;
            end else begin
              state_d     = S_DATA;
              remaining_d = asm_next[ADDR_WIDTH:0];
            end
          end
        end
      end

      S_DATA: begin
        // Retire the word strobed last cycle. The address is held on the
        // final word so it keeps pointing at the last location written.
        if (im_we_q) begin
          word_count_d = word_count_inc;
          if (word_count_inc == remaining_q) begin
            state_d     = S_DONE;
            cpu_rst_d   = 1'b0;
            load_done_d = 1'b1;
          end else begin
            im_addr_d = im_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        // Byte acceptance runs in parallel with the strobe cycle so the
        // stream is never stalled by a write.
        if (xfer) begin
          asm_d      = asm_next;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            im_we_d    = 1'b1;
            im_wdata_d = asm_next;
          end
        end
      end

      S_ERR: begin
        // Drain: bytes are accepted by in_ready and dropped here.
      end

      S_DONE: begin
      end

      default: state_d = S_LEN;
    endcase

    in_ready_d = (state_d != S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LEN;
      byte_idx_q   <= 2'd0;
      asm_q        <= 32'd0;
      remaining_q  <= '0;
      in_ready_q   <= 1'b0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= 32'd0;
      cpu_rst_q    <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      remaining_q  <= remaining_d;
      in_ready_q   <= in_ready_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
      word_count_q <= word_count_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign im_we      = im_we_q;
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Drives table-described loads (length, stream pacing, expected outcome) plus
// hand-written mid-load reset and post-done sequences. Expected memory writes
// are queued as each word's last byte is driven and popped by a monitor that
// watches the write strobe.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

  localparam int AW      = 8;
  localparam int TIMEOUT = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_rst;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_count;

  imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [31:0] len;
    int          gap;      // in_valid asserted once every 'gap' cycles
    logic        exp_done;
    logic        exp_err;
    int          exp_wc;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_writes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] data_word(input int i);
    if (i == 0) return 32'h0010_0513;
    if (i == 1) return 32'h0020_0593;
    return 32'h9E37_79B9 * 32'(i + 1);
  endfunction

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && im_we) begin
      n_writes++;
      check("spurious_we", 64'(exp_q.size() == 0), 64'd0);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(im_addr), 64'(e.addr));
        check("wr_data", 64'(im_wdata), 64'(e.data));
        check("wr_wc_before_inc", 64'(word_count), 64'(e.addr));
      end
    end
  end

  task automatic check_reset_vals(input string name);
    check(name,
          64'({in_ready, im_we, im_addr, im_wdata, cpu_rst, load_done, load_err, word_count}),
          64'({1'b0, 1'b0, {AW{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0, {(AW+1){1'b0}}}));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check_reset_vals("reset_values");
    exp_q.delete();
    n_writes = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(in_ready), 64'd1);
  endtask

  // Called at a negedge; returns at the negedge following the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int cnt;
    in_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    cnt = 0;
    while (!in_ready && cnt < TIMEOUT) begin
      @(negedge clk);
      cnt++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_load(input vec_t v);
    for (int b = 0; b < 4; b++) send_byte(v.len[8*b +: 8], v.gap);

    if (v.exp_err) begin
      check("err_flags", 64'({load_err, cpu_rst, in_ready, load_done}), 64'(4'b1110));
      for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1);
      check("err_no_writes", 64'(n_writes), 64'd0);
      check("err_sticky", 64'({load_err, cpu_rst, word_count}), 64'({1'b1, 1'b1, {(AW+1){1'b0}}}));
    end else if (v.len == 32'd0) begin
      check("zero_done", 64'({cpu_rst, load_done, in_ready, load_err}), 64'(4'b0100));
      @(negedge clk);
      check("zero_no_writes", 64'(n_writes), 64'd0);
      check("zero_wc", 64'(word_count), 64'd0);
    end else begin
      for (int w = 0; w < int'(v.len); w++) begin
        logic [31:0] d;
        d = data_word(w);
        for (int b = 0; b < 4; b++) begin
          if (b == 3) exp_q.push_back('{addr: AW'(w), data: d});
          send_byte(d[8*b +: 8], v.gap);
        end
      end
      // Final strobe is visible now; release follows one cycle later.
      check("last_strobe_cpu_rst", 64'({im_we, cpu_rst, load_done}), 64'(3'b110));
      @(negedge clk);
      check("done_flags", 64'({cpu_rst, load_done, load_err, in_ready, im_we}), 64'(5'b01000));
      check("done_wc", 64'(word_count), 64'(v.exp_wc));
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("done_expected", 64'(load_done), 64'(v.exp_done));
    end
  endtask

  initial begin
    vecs[0] = '{len: 32'd2,   gap: 1, exp_done: 1'b1, exp_err: 1'b0, exp_wc: 2};
    vecs[1] = '{len: 32'd2,   gap: 3, exp_done: 1'b1, exp_err: 1'b0, exp_wc: 2};
    vecs[2] = '{len: 32'd0,   gap: 1, exp_done: 1'b1, exp_err: 1'b0, exp_wc: 0};
    vecs[3] = '{len: 32'd257, gap: 1, exp_done: 1'b0, exp_err: 1'b1, exp_wc: 0};
    vecs[4] = '{len: 32'd256, gap: 1, exp_done: 1'b1, exp_err: 1'b0, exp_wc: 256};
    vecs[5] = '{len: 32'd5,   gap: 2, exp_done: 1'b1, exp_err: 1'b0, exp_wc: 5};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_load(vecs[i]);
    end

    // Post-done: further bytes are refused and change nothing.
    do_reset();
    run_load(vecs[0]);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hA0 + i);
      @(negedge clk);
      check("post_done_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    check("post_done_state", 64'({cpu_rst, im_we, word_count}), 64'({1'b0, 1'b0, 9'd2}));
    check("post_done_writes", 64'(n_writes), 64'd2);

    // Reset after 6 bytes of the nominal stream, then replay from scratch.
    do_reset();
    for (int b = 0; b < 4; b++) send_byte(vecs[0].len[8*b +: 8], 1);
    send_byte(8'h13, 1);
    send_byte(8'h05, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("midload_reset_values");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midload_ready", 64'(in_ready), 64'd1);
    run_load(vecs[0]);
    check("midload_writes", 64'(n_writes), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
